// File: rtl/cpu_pkg.sv
// cpu_pkg: shared hazard-unit state encodings and ecall halt id
package cpu_pkg;
  localparam logic [1:0] HZ_RUN    = 2'd0;
  localparam logic [1:0] HZ_DRAIN  = 2'd1;
  localparam logic [1:0] HZ_HALTED = 2'd2;
  localparam int ECALL_HALT_ID = 10;
endpackage

// File: rtl/hazard_reg_match.sv
// hazard_reg_match: x0-qualified register match between a used source and a producer rd
module hazard_reg_match (
  input  logic [4:0] rs_i,
  input  logic       use_i,
  input  logic [4:0] rd_i,
  output logic       hit_o
);
  assign hit_o = use_i & (rd_i != 5'd0) & (rs_i == rd_i);
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use stall, EX redirect flush and ecall-halt drain sequencing
// HAZARD_PERF_CNT_EN adds stall_count/flush_count performance counters.
module hazard_detection_unit
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_halt_req,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_mem_read,
  input  logic        ex_redirect,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        is_halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit1, hit2, load_use, run, drain, redirect, stall, halt_acc, advance;
  hazard_reg_match u_rs1 (.rs_i(id_rs1), .use_i(id_use_rs1), .rd_i(id_ex_rd), .hit_o(hit1));
  hazard_reg_match u_rs2 (.rs_i(id_rs2), .use_i(id_use_rs2), .rd_i(id_ex_rd), .hit_o(hit2));
  assign load_use = id_ex_mem_read & (hit1 | hit2);
  assign run      = state_q == HZ_RUN;
  assign drain    = state_q == HZ_DRAIN;
  // a redirect in DRAIN means the ecall itself was wrong-path
  assign redirect = ex_redirect & (run | drain);
  assign stall    = run & ~ex_redirect & load_use;
  assign halt_acc = run & ~ex_redirect & ~load_use & id_halt_req;
  assign advance  = redirect | (run & ~load_use & ~id_halt_req);
  assign pc_write     = ~reset & advance;
  assign if_id_write  = ~reset & advance;
  assign id_ex_bubble = reset | redirect | stall | ~run;
  assign if_id_flush  = reset | redirect;
  assign is_halted    = ~reset & (state_q == HZ_HALTED);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (redirect | halt_acc) begin
      state_d = redirect ? HZ_RUN : HZ_DRAIN;
      cnt_d   = '0;
    end else if (drain) begin
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(DRAIN_CYCLES - 1)) ? HZ_HALTED : HZ_DRAIN;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall) stall_count <= stall_count + 32'd1;
      if (redirect) flush_count <= flush_count + 32'd1;
    end
  end
`endif
endmodule
